// File: rtl/memory_writeback.sv
// Memory stage with MEM/WB pipeline register: a request/grant data-memory handshake,
// load-response wait, and a stall on upstream. Optional build macro MEM_TIMEOUT_EN adds a 16-cycle timeout with a sticky mem_err flag.
module memory_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        mem_op;
  logic        req, stall, timeout;
  logic [31:0] result;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       err_q;
`endif

  assign mem_op    = MemWriteM || (ResultSrcM == 2'b01);
  assign mem_we    = MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;

  // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE, REQ: begin
        if (state_q == REQ || mem_op) begin
          req = 1'b1;
          if (!mem_gnt) begin
            state_d = REQ;
            stall   = 1'b1;
          end else if (MemWriteM) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            stall   = 1'b1;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) state_d = IDLE;
        else            stall   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    // A wait that would repeat the current state on the last counter value gives up.
    if (state_q != IDLE && state_d == state_q && cnt_q == 4'hF) begin
      timeout = 1'b1;
      stall   = 1'b0;
      state_d = IDLE;
    end
`endif
  end

  // NOTE: the handshake outputs are combinational, so they are gated with rst to drop at once on an asynchronous reset.
  assign mem_req = rst && req;
  assign StallM  = rst && stall;

  always_comb begin
    case (ResultSrcM)
      2'b00:   result = ALUResultM;
      2'b01:   result = mem_rdata;
      2'b10:   result = PCPlus4M;
      default: result = 32'h0;
    endcase
    if (timeout) result = 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      RegWriteW <= 1'b0;
      RDW       <= 5'd0;
      ResultW   <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (stall) begin
        RegWriteW <= 1'b0;
        RDW       <= 5'd0;
        ResultW   <= 32'h0;
      end else begin
        RegWriteW <= RegWriteM && (RdM != 5'd0);
        RDW       <= RdM;
        ResultW   <= result;
      end
`ifdef MEM_TIMEOUT_EN
      if (state_d == IDLE)      cnt_q <= 4'd0;
      else if (state_q != IDLE) cnt_q <= cnt_q + 4'd1;
      if (timeout)              err_q <= 1'b1;
`endif
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_writeback.sv
// Self-checking bench for memory_writeback: directed scenarios plus randomized
// back-to-back traffic checked against a transaction-level retirement model.
module tb_memory_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [4:0]  RdM = 5'd0;
  logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0, PCPlus4M = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        StallM, RegWriteW, mem_err;
  logic [4:0]  RDW;
  logic [31:0] ResultW;

  int checks = 0;
  int errors = 0;

  memory_writeback dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Value an instruction writes back, straight from the result-select table.
  function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] rdata, input logic [31:0] pc4);
    case (sel)
      2'b00:   return alu;
      2'b01:   return rdata;
      2'b10:   return pc4;
      default: return 32'h0;
    endcase
  endfunction

  // One instruction. kind: 0 alu, 1 link, 2 zero, 3 load, 4 store.
  // d = cycles with grant low, r = cycles from grant to rvalid (loads).
  // Model: stalled on cycles 0..retire-1, request on 0..d, exactly one write-back at retire.
  task automatic run_op(input string name, input int kind, input logic rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input int d, input int r, input logic [31:0] ld);
    logic        is_mem, is_store, exp_we, exp_req;
    logic [31:0] exp_res;
    int          retire;
    is_store   = (kind == 4);
    is_mem     = (kind >= 3);
    retire     = !is_mem ? 0 : (is_store ? d : d + r);
    RegWriteM  = rw;
    MemWriteM  = is_store;
    ResultSrcM = (kind == 1) ? 2'b10 : (kind == 2) ? 2'b11 : (kind == 3) ? 2'b01 : 2'b00;
    RdM        = rd;
    ALUResultM = alu;
    WriteDataM = wd;
    PCPlus4M   = pc4;
    exp_we     = rw && (rd != 5'd0);
    exp_res    = wb_value(ResultSrcM, alu, ld, pc4);
    for (int c = 0; c <= retire; c++) begin
      if (is_mem && c <= d) mem_gnt = (c == d);
      else                  mem_gnt = 1'($urandom_range(0, 1));
      if (kind == 3 && c > d) mem_rvalid = (c == retire);
      else                    mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = (kind == 3 && c == retire) ? ld : $urandom;
      exp_req   = is_mem && (c <= d);
      @(negedge clk);
      checks++;
      if (StallM !== (c < retire)) begin
        errors++;
        $display("FAIL %s stall c=%0d: got %b want %b", name, c, StallM, (c < retire));
      end
      checks++;
      if (mem_req !== exp_req) begin
        errors++;
        $display("FAIL %s mem_req c=%0d: got %b want %b", name, c, mem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {is_store, alu, wd}) begin
          errors++;
          $display("FAIL %s mem_bus c=%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                   name, c, mem_we, mem_addr, mem_wdata, is_store, alu, wd);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (c < retire) begin
        if (RegWriteW !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble c=%0d: got RegWriteW=%b want 0", name, c, RegWriteW);
        end
      end else if ({RegWriteW, RDW, ResultW} !== {exp_we, rd, exp_res}) begin
        errors++;
        $display("FAIL %s writeback: got we=%b rd=%0d res=%h want we=%b rd=%0d res=%h",
                 name, RegWriteW, RDW, ResultW, exp_we, rd, exp_res);
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RdM = 5'd9;
    ALUResultM = 32'h40; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, StallM, RegWriteW, RDW, ResultW, mem_err} !== 40'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%b stall=%b we=%b rd=%0d res=%h err=%b want all 0",
               mem_req, StallM, RegWriteW, RDW, ResultW, mem_err);
    end
    RegWriteM = 1'b0; ResultSrcM = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    run_op("alu", 0, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_load();
    run_op("load", 3, 1'b1, 5'd8, 32'h100, 32'h0, 32'h0, 0, 3, 32'hDEADBEEF);
    run_op("after_load", 0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_store_wait();
    run_op("store", 4, 1'b0, 5'd3, 32'h200, 32'h5555AAAA, 32'h0, 2, 0, 32'h0);
  endtask

  task automatic test_link();
    run_op("link_x0", 1, 1'b1, 5'd0, 32'h9, 32'h0, 32'h88, 0, 0, 32'h0);
    run_op("link_x1", 1, 1'b1, 5'd1, 32'h9, 32'h0, 32'h44, 0, 0, 32'h0);
    run_op("zero_sel", 2, 1'b1, 5'd2, 32'h9, 32'h0, 32'h44, 0, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RdM = 5'd4; ALUResultM = 32'h300;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (StallM !== 1'b1) begin
      errors++;
      $display("FAIL mid_resp_stall: got %b want 1", StallM);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, StallM, RegWriteW, ResultW} !== 35'h0) begin
      errors++;
      $display("FAIL mid_reset_drop: got req=%b stall=%b we=%b res=%h want 0",
               mem_req, StallM, RegWriteW, ResultW);
    end
    @(posedge clk); #1;
    ResultSrcM = 2'b00; RdM = 5'd7; ALUResultM = 32'h77;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, StallM} !== 2'b00) begin
      errors++;
      $display("FAIL late_rvalid_stall: got req=%b stall=%b want 0 0", mem_req, StallM);
    end
    @(posedge clk); #1;
    checks++;
    if ({RegWriteW, RDW, ResultW} !== {1'b1, 5'd7, 32'h77}) begin
      errors++;
      $display("FAIL late_rvalid_wb: got we=%b rd=%0d res=%h want 1 7 00000077",
               RegWriteW, RDW, ResultW);
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 4);
      run_op("random", kind, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4), $urandom);
    end
    checks++;
`ifdef MEM_TIMEOUT_EN
    if (mem_err !== 1'b0) begin
`else
    if (mem_err !== 1'b0) begin
`endif
      errors++;
      $display("FAIL mem_err_idle: got %b want 0", mem_err);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RdM = 5'd6; ALUResultM = 32'h500;
    mem_rvalid = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      mem_gnt = (c == 0);
      @(negedge clk);
      checks++;
      if (StallM !== (c < 16)) begin
        errors++;
        $display("FAIL timeout_stall c=%0d: got %b want %b", c, StallM, (c < 16));
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({RegWriteW, RDW, ResultW, mem_err} !== {1'b1, 5'd6, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_retire: got we=%b rd=%0d res=%h err=%b want 1 6 0 1",
               RegWriteW, RDW, ResultW, mem_err);
    end
    run_op("post_timeout", 0, 1'b0, 5'd0, 32'h1, 32'h0, 32'h0, 0, 0, 32'h0);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b want 1", mem_err);
    end
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b want 0", mem_err);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_wait();
    test_link();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
